// File: rtl/flop_pkg.sv
// Shared types and field widths for the FP-adder post-normalization stage.
package flop_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/flop_norm.sv
// Normalizes a raw FP add/sub result: one right shift for carry-out, or
// iterative left shifts (one per cycle) until the hidden bit is set.
module flop_norm
    import flop_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [EXP_W-1:0]     in_exp,
    input  logic [MAN_W+1:0]     in_mant,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_f,
    output logic                 out_zero,
    output logic                 out_ovf,
    output logic                 out_unf
);

    state_t             state;
    logic               sign_p0;
    logic [EXP_W:0]     exp_p0;
    logic [MAN_W+1:0]   mant_p0;
    logic [EXP_W:0]     exp_inc;
    logic [EXP_W:0]     exp_dec;

    // Saturated encodings for out-of-range exponents.
    function automatic logic [31:0] sat_inf(input logic s);
        return {s, EXP_MAX, {MAN_W{1'b0}}};
    endfunction

    function automatic logic [31:0] sat_flush(input logic s);
        return {s, 31'h0};
    endfunction

    // Nine-bit exponent so +1/-1 can never wrap unnoticed.
    assign exp_inc  = exp_p0 + 9'd1;
    assign exp_dec  = exp_p0 - 9'd1;
    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_f     <= '0;
            out_zero  <= 1'b0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_p0 <= in_sign;
                        exp_p0  <= {1'b0, in_exp};
                        mant_p0 <= in_mant;
                        state   <= SHIFT;
                    end
                end
                // ---- iterative normalization, one step per cycle ----
                SHIFT: begin
                    if (mant_p0 == '0) begin
                        out_f     <= '0;
                        out_zero  <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (exp_p0 == {1'b0, EXP_MAX}) begin
                        out_f     <= sat_inf(sign_p0);
                        out_ovf   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (mant_p0[MAN_W+1]) begin
                        if (exp_inc[EXP_W] || (exp_inc[EXP_W-1:0] == EXP_MAX)) begin
                            out_f   <= sat_inf(sign_p0);
                            out_ovf <= 1'b1;
                        end else begin
                            out_f <= {sign_p0, exp_inc[EXP_W-1:0], mant_p0[MAN_W:1]};
                        end
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (mant_p0[MAN_W]) begin
                        out_f     <= {sign_p0, exp_p0[EXP_W-1:0], mant_p0[MAN_W-1:0]};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (exp_p0 <= 9'd1) begin
                        out_f     <= sat_flush(sign_p0);
                        out_unf   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        mant_p0 <= mant_p0 << 1;
                        exp_p0  <= exp_dec;
                    end
                end
                // ---- hold result until the consumer takes it ----
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_zero  <= 1'b0;
                        out_ovf   <= 1'b0;
                        out_unf   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flop_norm.sv
// Directed bench for flop_norm: normal, carry, deep shift, zero, underflow,
// overflow, backpressure and reset-in-flight.
module tb_flop_norm;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_f;
    logic        out_zero;
    logic        out_ovf;
    logic        out_unf;

    int n_tests = 0;
    int n_fail  = 0;

    flop_norm dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_f(out_f), .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand for a single edge (E0); inputs change #1 after edges.
    task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
        tick();
        in_valid = 1'b0;
    endtask

    // Returns edges after E0 until out_valid is seen; 999 on timeout.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = 999;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_tests++;
        if ({out_valid, out_zero, out_ovf, out_unf} !== 4'b0 || out_f !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v/z/o/u=%b f=%h, need 0000 f=00000000",
                     {out_valid, out_zero, out_ovf, out_unf}, out_f);
        end
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready_low: got %b, need 0", in_ready);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready_idle: got %b, need 1", in_ready);
        end
    endtask

    task automatic test_normal();
        int lat;
        send(1'b0, 8'h80, 25'h0800000);
        wait_out(lat);
        n_tests++;
        if (lat !== 1 || out_f !== 32'h40000000 || {out_zero, out_ovf, out_unf} !== 3'b000) begin
            n_fail++;
            $display("FAIL normal: got lat=%0d f=%h zou=%b, need lat=1 f=40000000 zou=000",
                     lat, out_f, {out_zero, out_ovf, out_unf});
        end
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL normal_in_ready_done: got %b, need 0", in_ready);
        end
        drain();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL normal_handshake: got valid=%b ready=%b, need 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_carry();
        int lat;
        send(1'b0, 8'h80, 25'h1800000);
        wait_out(lat);
        n_tests++;
        if (lat !== 1 || out_f !== 32'h40C00000 || {out_zero, out_ovf, out_unf} !== 3'b000) begin
            n_fail++;
            $display("FAIL carry: got lat=%0d f=%h zou=%b, need lat=1 f=40c00000 zou=000",
                     lat, out_f, {out_zero, out_ovf, out_unf});
        end
        drain();
    endtask

    task automatic test_shift();
        int lat;
        send(1'b0, 8'h80, 25'h0000001);
        wait_out(lat);
        n_tests++;
        if (lat !== 24 || out_f !== 32'h34800000 || {out_zero, out_ovf, out_unf} !== 3'b000) begin
            n_fail++;
            $display("FAIL deep_shift: got lat=%0d f=%h zou=%b, need lat=24 f=34800000 zou=000",
                     lat, out_f, {out_zero, out_ovf, out_unf});
        end
        drain();
        send(1'b0, 8'h80, 25'h0400000);
        wait_out(lat);
        n_tests++;
        if (lat !== 2 || out_f !== 32'h3F800000) begin
            n_fail++;
            $display("FAIL one_shift: got lat=%0d f=%h, need lat=2 f=3f800000", lat, out_f);
        end
        drain();
    endtask

    task automatic test_zero_unf();
        int lat;
        send(1'b1, 8'h80, 25'h0000000);
        wait_out(lat);
        n_tests++;
        if (lat !== 1 || out_f !== 32'h0 || {out_zero, out_ovf, out_unf} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero: got lat=%0d f=%h zou=%b, need lat=1 f=00000000 zou=100",
                     lat, out_f, {out_zero, out_ovf, out_unf});
        end
        drain();
        send(1'b0, 8'h05, 25'h0000001);
        wait_out(lat);
        n_tests++;
        if (lat !== 5 || out_f !== 32'h0 || {out_zero, out_ovf, out_unf} !== 3'b001) begin
            n_fail++;
            $display("FAIL underflow: got lat=%0d f=%h zou=%b, need lat=5 f=00000000 zou=001",
                     lat, out_f, {out_zero, out_ovf, out_unf});
        end
        drain();
    endtask

    task automatic test_overflow();
        int lat;
        send(1'b0, 8'hFE, 25'h1000000);
        wait_out(lat);
        n_tests++;
        if (lat !== 1 || out_f !== 32'h7F800000 || {out_zero, out_ovf, out_unf} !== 3'b010) begin
            n_fail++;
            $display("FAIL overflow_carry: got lat=%0d f=%h zou=%b, need lat=1 f=7f800000 zou=010",
                     lat, out_f, {out_zero, out_ovf, out_unf});
        end
        drain();
        send(1'b1, 8'hFF, 25'h0800000);
        wait_out(lat);
        n_tests++;
        if (out_f !== 32'hFF800000 || {out_zero, out_ovf, out_unf} !== 3'b010) begin
            n_fail++;
            $display("FAIL overflow_max_exp: got f=%h zou=%b, need f=ff800000 zou=010",
                     out_f, {out_zero, out_ovf, out_unf});
        end
        drain();
    endtask

    task automatic test_backpressure();
        int lat;
        send(1'b1, 8'h7F, 25'h0C00000);
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            // a competing operand while busy must be ignored
            in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h10; in_mant = 25'h0000003;
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_f !== 32'hBFC00000) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got valid=%b ready=%b f=%h, need 1 0 bfc00000",
                         i, out_valid, in_ready, out_f);
            end
            tick();
        end
        in_valid = 1'b0;
        drain();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: got valid=%b ready=%b, need 0 1", out_valid, in_ready);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL busy_input_ignored: got valid=%b, need 0", out_valid);
        end
    endtask

    task automatic test_rst_shift();
        int lat;
        int seen = 0;
        send(1'b0, 8'h80, 25'h0000001);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_shift: got valid=%b ready=%b, need 0 0", out_valid, in_ready);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_shift_idle: got ready=%b, need 1", in_ready);
        end
        for (int i = 0; i < 30; i++) begin
            if (out_valid) seen++;
            tick();
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL rst_no_stale: got %0d valid cycles, need 0", seen);
        end
        send(1'b0, 8'h80, 25'h1800000);
        wait_out(lat);
        n_tests++;
        if (lat !== 1 || out_f !== 32'h40C00000) begin
            n_fail++;
            $display("FAIL post_rst_op: got lat=%0d f=%h, need lat=1 f=40c00000", lat, out_f);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || out_f !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_done: got valid=%b f=%h, need 0 00000000", out_valid, out_f);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_normal();
        test_carry();
        test_shift();
        test_zero_unf();
        test_overflow();
        test_backpressure();
        test_rst_shift();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
